// File: rtl/dac_pkg.sv
// Shared types and constants for the LTC2624 DAC path: FSM states, command/address
// codes and the 32-bit frame packing used by both the SPI transmitter and the DAC control logic.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TAIL,
        DONE
    } dac_state_t;

    localparam int         FRAME_BITS       = 32;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] CMD_NOP          = 4'b1111;
    localparam logic [3:0] ADDR_ALL         = 4'b1111;

    // LTC2624 32-bit word: 8 don't-care bits, command, address, 12-bit code, 4 don't-care bits.
    function automatic logic [31:0] pack_frame(input logic [3:0]  cmd,
                                               input logic [3:0]  addr,
                                               input logic [11:0] code);
        return {8'h00, cmd, addr, code, 4'h0};
    endfunction

endpackage

// File: rtl/dac_sck_gen.sv
// SPI clock divider: registered sck toggling every SCK_HALF enabled cycles, with rise/fall
// strobes that mark the clock edge on which sck will change. clr forces sck low and the count to 0.
module dac_sck_gen #(
    parameter int SCK_HALF = 2
) (
    input  logic CLK50MHZ,
    input  logic clr,
    input  logic en,
    output logic sck,
    output logic rise_en,
    output logic fall_en
);

    localparam int CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCK_HALF - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick    = en && (cnt == CNT_LAST);
    assign rise_en = tick && !sck;
    assign fall_en = tick && sck;

    always_ff @(posedge CLK50MHZ) begin
        if (clr) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                sck <= ~sck;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// LTC2624 SPI transmitter: latches {cmd, addr, data} on dactrig, shifts a 32-bit frame MSB-first
// under DAC_CS and pulses dacdone. Optional echo capture into rdback when DAC_READBACK_EN is defined.
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int SCK_HALF   = 2,
    parameter int FRAME_BITS = 32
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic [11:0] data,
    input  logic [3:0]  address,
    input  logic [3:0]  command,
    input  logic        dactrig,
    output logic        dacdone,
    output logic        busy,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    output logic        DAC_CS,
    output logic        DAC_CLR,
    input  logic        SPI_MISO,
    output logic [31:0] rdback
);

    localparam int BCW = $clog2(FRAME_BITS);

    dac_state_t            state, nstate;
    logic [FRAME_BITS-1:0] shreg;
    logic [BCW-1:0]        bitcnt;
    logic                  sck, rise_en, fall_en;
    logic                  sck_run, sck_clr;

    assign sck_run = (state == SHIFT) || (state == TAIL);
    // Clearing whenever the next state is not a shifting state keeps the first low phase full length.
    assign sck_clr = RST || !((nstate == SHIFT) || (nstate == TAIL));

    dac_sck_gen #(
        .SCK_HALF (SCK_HALF)
    ) u_sck (
        .CLK50MHZ (CLK50MHZ),
        .clr      (sck_clr),
        .en       (sck_run),
        .sck      (sck),
        .rise_en  (rise_en),
        .fall_en  (fall_en)
    );

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (dactrig) nstate = SHIFT;
            SHIFT:   if (fall_en && (bitcnt == '0)) nstate = TAIL;
            // TAIL ends one SCK half-period after the last falling edge, while SCK stays low.
            TAIL:    if (rise_en) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            shreg <= '0;
        end else if ((state == IDLE) && dactrig) begin
            shreg <= FRAME_BITS'(dac_pkg::pack_frame(command, address, data));
        end else if ((state == SHIFT) && fall_en) begin
            shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge CLK50MHZ) begin
        if ((state == IDLE) && dactrig) begin
            bitcnt <= BCW'(FRAME_BITS - 1);
        end else if ((state == SHIFT) && fall_en) begin
            bitcnt <= bitcnt - 1'b1;
        end
    end

    assign SPI_SCK  = sck;
    assign SPI_MOSI = shreg[FRAME_BITS-1];
    assign DAC_CS   = !sck_run;
    assign busy     = (state != IDLE);
    assign dacdone  = (state == DONE);
    assign DAC_CLR  = ~RST;

`ifdef DAC_READBACK_EN
    logic [31:0] cap;

    always_ff @(posedge CLK50MHZ) begin
        if ((state == SHIFT) && rise_en) begin
            cap <= {cap[30:0], SPI_MISO};
        end
    end

    // Published on entry to DONE so rdback is already valid during the dacdone cycle.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            rdback <= '0;
        end else if ((state == TAIL) && rise_en) begin
            rdback <= cap;
        end
    end
`else
    logic unused_miso;

    assign unused_miso = SPI_MISO;
    assign rdback      = '0;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: an LTC2624 model shifts MOSI on SCK rise and echoes the previous
// word on MISO; each dacdone pops the expected frame and checks word, SCK count, CS length, latency.
`timescale 1ns/1ps
`ifndef TB_SCK_HALF
`define TB_SCK_HALF 2
`endif
module tb_dac_spi_tx;

    localparam int H      = `TB_SCK_HALF;
    localparam int CS_LOW = 65 * H;
    localparam int LAT    = 65 * H + 1;
    // Back-to-back frames: CS stays high for the DONE cycle plus the IDLE cycle that samples dactrig.
    localparam int GAP    = 2;

    logic        CLK50MHZ = 1'b0;
    logic        RST      = 1'b1;
    logic        dactrig  = 1'b0;
    logic [11:0] data     = '0;
    logic [3:0]  address  = '0;
    logic [3:0]  command  = '0;
    logic        dacdone, busy, SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR, SPI_MISO;
    logic [31:0] rdback;

    dac_spi_tx #(
        .SCK_HALF (H)
    ) dut (
        .CLK50MHZ (CLK50MHZ),
        .RST      (RST),
        .data     (data),
        .address  (address),
        .command  (command),
        .dactrig  (dactrig),
        .dacdone  (dacdone),
        .busy     (busy),
        .SPI_SCK  (SPI_SCK),
        .SPI_MOSI (SPI_MOSI),
        .DAC_CS   (DAC_CS),
        .DAC_CLR  (DAC_CLR),
        .SPI_MISO (SPI_MISO),
        .rdback   (rdback)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge CLK50MHZ) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] word;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          gap_q[$];
    logic [31:0] drv_word = '0;

    // Accepted requests are recorded with the word the stimulus expects on the wire.
    always @(negedge CLK50MHZ) begin
        #2;
        if (dactrig && !busy && !RST) sb.push_back('{drv_word, cyc});
    end

    logic [31:0] rx        = '0;
    logic [31:0] echo_sr   = '0;
    logic [31:0] echo_word = '0;
    logic [31:0] last_word = '0;
    int          rises     = 0;
    int          cs_low    = 0;
    int          cs_high   = 0;
    int          done_cnt  = 0;
    logic        sck_prev  = 1'b0;
    logic        cs_prev   = 1'b1;

    assign SPI_MISO = echo_sr[31];

    always @(negedge CLK50MHZ) begin
        exp_t        e;
        logic [31:0] exp_rd;
        if (!DAC_CS && cs_prev) begin
            gap_q.push_back(cs_high);
            cs_high   = 0;
            cs_low    = 0;
            rises     = 0;
            rx        = '0;
            echo_word = last_word;
            echo_sr   = last_word;
        end
        if (!DAC_CS) cs_low++;
        else         cs_high++;
        if (SPI_SCK && !sck_prev) begin
            rx = {rx[30:0], SPI_MOSI};
            rises++;
        end
        if (!SPI_SCK && sck_prev) echo_sr = {echo_sr[30:0], 1'b0};
        if (dacdone) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_dacdone: got dacdone at cycle %0d, required none", cyc);
            end else begin
                e = sb.pop_front();
`ifdef DAC_READBACK_EN
                exp_rd = echo_word;
`else
                exp_rd = '0;
`endif
                check("frame_word", rx, e.word);
                check("sck_rises", rises, 32);
                check("cs_low_len", cs_low, CS_LOW);
                check("done_latency", cyc - e.cyc, LAT);
                check("rdback", rdback, exp_rd);
                last_word = rx;
            end
            done_cnt++;
        end
        sck_prev = SPI_SCK;
        cs_prev  = DAC_CS;
    end

    task automatic issue(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d,
                         input logic [31:0] w);
        @(negedge CLK50MHZ); #1;
        command  = c;
        address  = a;
        data     = d;
        drv_word = w;
        dactrig  = 1'b1;
        @(negedge CLK50MHZ); #1;
        dactrig  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK50MHZ);
        #1;
    endtask

    task automatic wait_done(input int target, input string name);
        int k;
        k = 0;
        while ((done_cnt < target) && (k < 4000)) begin
            @(negedge CLK50MHZ); #1;
            k++;
        end
        n_checks++;
        if (done_cnt < target) begin
            n_fail++;
            $display("FAIL %s: dacdone count %0d, required %0d within bound", name, done_cnt, target);
        end
    endtask

    initial begin
        idle(3);
        check("rst_cs", DAC_CS, 1);
        check("rst_sck", SPI_SCK, 0);
        check("rst_mosi", SPI_MOSI, 0);
        check("rst_busy", busy, 0);
        check("rst_done", dacdone, 0);
        check("rst_clr", DAC_CLR, 0);
        check("rst_rdback", rdback, 0);
        RST = 1'b0;
        #1;
        check("clr_released", DAC_CLR, 1);
        idle(2);

        // T1 with T2 retriggers at +10 and +60 carrying a different word
        issue(4'h3, 4'h0, 12'hABC, 32'h0030ABC0);
        idle(9);
        command = 4'hF; address = 4'hF; data = 12'h555; drv_word = 32'h00FF5550; dactrig = 1'b1;
        check("busy_at_10", busy, 1);
        idle(1);
        dactrig = 1'b0;
        idle(49);
        dactrig = 1'b1;
        check("busy_at_60", busy, 1);
        idle(1);
        dactrig = 1'b0;
        wait_done(1, "t1_done");
        idle(6);
        check("t2_single_done", done_cnt, 1);
        check("t2_queue_empty", sb.size(), 0);

        // T3: dactrig held across three frames
        command = 4'h3; address = 4'hF; data = 12'h000; drv_word = 32'h003F0000; dactrig = 1'b1;
        wait_done(2, "t3_f1");
        data = 12'hFFF; drv_word = 32'h003FFFF0;
        wait_done(3, "t3_f2");
        data = 12'h800; drv_word = 32'h003F8000;
        wait_done(4, "t3_f3");
        dactrig = 1'b0;
        check("t3_gap1", gap_q[gap_q.size()-2], GAP);
        check("t3_gap2", gap_q[gap_q.size()-1], GAP);
        idle(5);
        check("t3_idle_busy", busy, 0);

        // T4: reset 40 cycles into a frame
        issue(4'h3, 4'h1, 12'h321, 32'h00313210);
        idle(39);
        RST = 1'b1;
        check("abort_sb_size", sb.size(), 1);
        sb.delete();
        idle(1);
        check("abort_cs", DAC_CS, 1);
        check("abort_sck", SPI_SCK, 0);
        check("abort_busy", busy, 0);
        check("abort_done", dacdone, 0);
        check("abort_clr", DAC_CLR, 0);
        idle(1);
        check("abort_clr2", DAC_CLR, 0);
        RST = 1'b0;
        #1;
        check("abort_clr_rel", DAC_CLR, 1);
        idle(20);
        check("abort_no_done", done_cnt, 4);
        issue(4'h3, 4'h2, 12'h123, 32'h00321230);
        wait_done(5, "t4_clean");
        idle(3);
        issue(4'hF, 4'hF, 12'h5A5, 32'h00FF5A50);
        wait_done(6, "t6_last");
        idle(4);
        check("final_queue_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
